// File: rtl/regfile_mp_sb.sv
// Register file with two write ports, combinational write-to-read bypass and a
// built-in scoreboard of in-flight destination registers for RAW stall detection.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH    = 1 << ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   busy_cnt_reg;
    logic [ADDR_W:0]   busy_cnt_next;
    logic              wa_ok;
    logic              wb_ok;
    logic              iss_ok;

    assign wa_ok  = wa_en  && !(HAS_ZERO && (wa_addr  == '0));
    assign wb_ok  = wb_en  && !(HAS_ZERO && (wb_addr  == '0));
    assign iss_ok = iss_en && !(HAS_ZERO && (iss_addr == '0));

    // Port B is written last so it wins an address collision with port A.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            if (wa_ok) regs_reg[wa_addr] <= wa_data;
            if (wb_ok) regs_reg[wb_addr] <= wb_data;
        end
    end

    // Issue is applied after the write-back clears so a new producer keeps the bit set.
    always_comb begin
        busy_next = busy_reg;
        if (wa_en) busy_next[wa_addr] = 1'b0;
        if (wb_en) busy_next[wb_addr] = 1'b0;
        if (flush) begin
            busy_next = '0;
        end else if (iss_ok) begin
            busy_next[iss_addr] = 1'b1;
        end
    end

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_next = busy_cnt_next + (ADDR_W + 1)'(busy_next[i]);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              is_zero;
            logic              hit_a;
            logic              hit_b;

            assign addr    = rd_addr[gi*ADDR_W +: ADDR_W];
            assign is_zero = HAS_ZERO && (addr == '0);
            assign hit_a   = wa_en && (wa_addr == addr);
            assign hit_b   = wb_en && (wb_addr == addr);

            always_comb begin
                if (is_zero)    data = '0;
                else if (hit_b) data = wb_data;
                else if (hit_a) data = wa_data;
                else            data = regs_reg[addr];
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data;
            assign rd_busy[gi] = busy_reg[addr] && !hit_a && !hit_b && !is_zero;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_mp_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     sysclk = 1'b0;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en;
    logic [ADDR_W-1:0]        wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] m_regs [DEPTH];
    bit                m_busy [DEPTH];

    regfile_mp_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .sysclk(sysclk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 sysclk = ~sysclk;

    // Reference read: the priority list applied to the model state and live write inputs.
    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        if (wa_en && wa_addr == a) return wa_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        if ((wa_en && wa_addr == a) || (wb_en && wb_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = '0; wa_data = '0;
        wb_en = 0; wb_addr = '0; wb_data = '0;
        iss_en = 0; iss_addr = '0; flush = 0;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    // Advance the model by one edge using the inputs currently driven, then clock the DUT.
    task automatic commit_cycle();
        if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
        if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        end else begin
            if (wa_en) m_busy[wa_addr] = 1'b0;
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        int e0 = n_err;
        idle();
        wa_en = 1; wa_addr = 5'd3; wa_data = 32'hDEAD_BEEF;
        iss_en = 1; iss_addr = 5'd6;
        commit_cycle();
        idle();
        #2;
        wa_en = 1; wa_addr = 5'd3; wa_data = 32'h0000_1234;
        reset = 1;
        set_rd(0, 5'd3); set_rd(1, 5'd6);
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h0000_1234) begin
            n_err++; $display("FAIL reset_bypass: got %h want %h", rd_data[31:0], 32'h0000_1234);
        end
        n_cmp++;
        if (rd_busy !== 2'b00) begin
            n_err++; $display("FAIL reset_busy_in_reset: got %b want 00", rd_busy);
        end
        @(posedge sysclk);
        #1;
        reset = 0;
        idle();
        model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, ADDR_W'(a)); set_rd(1, ADDR_W'(DEPTH - 1 - a));
            #1;
            n_cmp++;
            if (rd_data !== '0) begin
                n_err++; $display("FAIL reset_read a=%0d: got %h want 0", a, rd_data);
            end
            n_cmp++;
            if (rd_busy !== 2'b00) begin
                n_err++; $display("FAIL reset_rd_busy a=%0d: got %b want 00", a, rd_busy);
            end
        end
        n_cmp++;
        if (busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL reset_busy_cnt: got %0d want 0", busy_cnt);
        end
        $display("test_reset: %0d new errors", n_err - e0);
    endtask

    task automatic test_collision();
        int e0 = n_err;
        idle();
        wa_en = 1; wa_addr = 5'd7; wa_data = 32'h1111_1111;
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'h2222_2222;
        set_rd(0, 5'd7); set_rd(1, 5'd8);
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h2222_2222) begin
            n_err++; $display("FAIL collision_bypass: got %h want 22222222", rd_data[31:0]);
        end
        commit_cycle();
        idle();
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h2222_2222) begin
            n_err++; $display("FAIL collision_stored: got %h want 22222222", rd_data[31:0]);
        end
        $display("test_collision: %0d new errors", n_err - e0);
    endtask

    task automatic test_raw();
        int e0 = n_err;
        idle();
        iss_en = 1; iss_addr = 5'd5;
        set_rd(0, 5'd5);
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL raw_same_cycle_issue: got %b want 0", rd_busy[0]);
        end
        commit_cycle();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin
            n_err++; $display("FAIL raw_busy_c1: got %b want 1", rd_busy[0]);
        end
        n_cmp++;
        if (busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL raw_cnt_c1: got %0d want 1", busy_cnt);
        end
        commit_cycle();
        commit_cycle();
        wa_en = 1; wa_addr = 5'd5; wa_data = 32'h0000_ABCD;
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h0000_ABCD) begin
            n_err++; $display("FAIL raw_writeback_c3: got busy=%b data=%h want busy=0 data=0000abcd",
                              rd_busy[0], rd_data[31:0]);
        end
        commit_cycle();
        idle();
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL raw_cnt_c4: got %0d want 0", busy_cnt);
        end
        $display("test_raw: %0d new errors", n_err - e0);
    endtask

    task automatic test_race();
        int e0 = n_err;
        idle();
        iss_en = 1; iss_addr = 5'd9;
        commit_cycle();
        idle();
        wb_en = 1; wb_addr = 5'd9; wb_data = 32'hCAFE_0009;
        iss_en = 1; iss_addr = 5'd9;
        commit_cycle();
        idle();
        set_rd(0, 5'd9);
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin
            n_err++; $display("FAIL race_busy: got %b want 1", rd_busy[0]);
        end
        n_cmp++;
        if (busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL race_cnt: got %0d want 1", busy_cnt);
        end
        n_cmp++;
        if (rd_data[31:0] !== 32'hCAFE_0009) begin
            n_err++; $display("FAIL race_data: got %h want cafe0009", rd_data[31:0]);
        end
        $display("test_race: %0d new errors", n_err - e0);
    endtask

    task automatic test_zero_reg();
        int e0 = n_err;
        idle();
        iss_en = 1; iss_addr = 5'd0;
        wa_en = 1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
        set_rd(0, 5'd0);
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL zero_bypass: got data=%h busy=%b want 0/0", rd_data[31:0], rd_busy[0]);
        end
        commit_cycle();
        idle();
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL zero_stored: got data=%h busy=%b want 0/0", rd_data[31:0], rd_busy[0]);
        end
        n_cmp++;
        if (busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL zero_cnt: got %0d want 1", busy_cnt);
        end
        $display("test_zero_reg: %0d new errors", n_err - e0);
    endtask

    task automatic test_flush();
        int e0 = n_err;
        for (int a = 1; a < DEPTH; a++) begin
            idle();
            iss_en = 1; iss_addr = ADDR_W'(a);
            commit_cycle();
        end
        idle();
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd31) begin
            n_err++; $display("FAIL flush_fill_cnt: got %0d want 31", busy_cnt);
        end
        flush = 1;
        iss_en = 1; iss_addr = 5'd3;
        wa_en = 1; wa_addr = 5'd4; wa_data = 32'h0000_0055;
        commit_cycle();
        idle();
        set_rd(0, 5'd3); set_rd(1, 5'd4);
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt);
        end
        n_cmp++;
        if (rd_busy !== 2'b00) begin
            n_err++; $display("FAIL flush_rd_busy: got %b want 00", rd_busy);
        end
        n_cmp++;
        if (rd_data[63:32] !== 32'h0000_0055) begin
            n_err++; $display("FAIL flush_write: got %h want 00000055", rd_data[63:32]);
        end
        $display("test_flush: %0d new errors", n_err - e0);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 7));
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic test_random();
        int e0 = n_err;
        for (int n = 0; n < 400; n++) begin
            wa_en = ($urandom_range(0, 1) == 1); wa_addr = rand_addr(); wa_data = $urandom;
            wb_en = ($urandom_range(0, 2) == 0); wb_addr = rand_addr(); wb_data = $urandom;
            iss_en = ($urandom_range(0, 4) < 3); iss_addr = rand_addr();
            flush = ($urandom_range(0, 24) == 0);
            set_rd(0, rand_addr()); set_rd(1, rand_addr());
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                n_cmp++;
                if (rd_data[k*DATA_W +: DATA_W] !== exp_data(rd_addr[k*ADDR_W +: ADDR_W])) begin
                    n_err++; $display("FAIL rand_data n=%0d k=%0d: got %h want %h", n, k,
                                      rd_data[k*DATA_W +: DATA_W], exp_data(rd_addr[k*ADDR_W +: ADDR_W]));
                end
                n_cmp++;
                if (rd_busy[k] !== exp_busy(rd_addr[k*ADDR_W +: ADDR_W])) begin
                    n_err++; $display("FAIL rand_busy n=%0d k=%0d: got %b want %b", n, k,
                                      rd_busy[k], exp_busy(rd_addr[k*ADDR_W +: ADDR_W]));
                end
            end
            n_cmp++;
            if (busy_cnt !== 6'(exp_cnt())) begin
                n_err++; $display("FAIL rand_cnt n=%0d: got %0d want %0d", n, busy_cnt, exp_cnt());
            end
            commit_cycle();
        end
        idle();
        $display("test_random: %0d new errors", n_err - e0);
    endtask

    initial begin
        reset = 1;
        rd_addr = '0;
        idle();
        model_clear();
        repeat (2) @(posedge sysclk);
        #1;
        reset = 0;
        test_reset();
        test_collision();
        test_raw();
        test_race();
        test_zero_reg();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
